// File: rtl/lane_demux_4x9.sv
// Rebuilds four parallel lane words from the serialized clk4f word stream.
// A 2-bit phase steers words into staging slots; sync_in realigns to lane0.
module lane_demux_4x9 #(
    parameter int unsigned DATA_W = 9,
    parameter int unsigned CNT_W  = 8
) (
    input  logic              clk4f,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_in,
    input  logic              sync_in,
    output logic [DATA_W-1:0] data0,
    output logic [DATA_W-1:0] data1,
    output logic [DATA_W-1:0] data2,
    output logic [DATA_W-1:0] data3,
    output logic [3:0]        lane_valid,
    output logic              frame_valid,
    output logic              resync,
    output logic [CNT_W-1:0]  frame_cnt
);

    localparam int unsigned MSB = DATA_W - 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [1:0]        phase_q, phase_d;
    logic [DATA_W-1:0] slot0_q, slot0_d;
    logic [DATA_W-1:0] slot1_q, slot1_d;
    logic [DATA_W-1:0] slot2_q, slot2_d;
    logic [DATA_W-1:0] data0_q, data0_d;
    logic [DATA_W-1:0] data1_q, data1_d;
    logic [DATA_W-1:0] data2_q, data2_d;
    logic [DATA_W-1:0] data3_q, data3_d;
    logic [3:0]        lane_valid_q, lane_valid_d;
    logic              frame_valid_q, frame_valid_d;
    logic              resync_q, resync_d;
    logic [CNT_W-1:0]  frame_cnt_q, frame_cnt_d;
    logic [3:0]        new_valid;

    // MSBs of the frame that completes this cycle, only meaningful at phase 3
    assign new_valid = {data_in[MSB], slot2_q[MSB], slot1_q[MSB], slot0_q[MSB]};

    // Next-state: slot steering, frame completion and realignment
    always_comb begin
        phase_d       = phase_q;
        slot0_d       = slot0_q;
        slot1_d       = slot1_q;
        slot2_d       = slot2_q;
        data0_d       = data0_q;
        data1_d       = data1_q;
        data2_d       = data2_q;
        data3_d       = data3_q;
        lane_valid_d  = lane_valid_q;
        frame_valid_d = 1'b0;
        resync_d      = 1'b0;
        frame_cnt_d   = frame_cnt_q;

        if (sync_in) begin
            // Realign: this word is lane0, any partial frame is dropped
            slot0_d  = data_in;
            phase_d  = 2'd1;
            resync_d = (phase_q != 2'd0);
        end else begin
            case (phase_q)
                2'd0: slot0_d = data_in;
                2'd1: slot1_d = data_in;
                2'd2: slot2_d = data_in;
                default: begin
                    data0_d       = slot0_q;
                    data1_d       = slot1_q;
                    data2_d       = slot2_q;
                    data3_d       = data_in;
                    lane_valid_d  = new_valid;
                    frame_valid_d = 1'b1;
                    if ((new_valid != 4'd0) && (frame_cnt_q != CNT_MAX)) begin
                        frame_cnt_d = frame_cnt_q + CNT_W'(1);
                    end
                end
            endcase
            phase_d = phase_q + 2'd1;
        end
    end

    always_ff @(posedge clk4f) begin
        if (reset) begin
            phase_q       <= 2'd0;
            slot0_q       <= '0;
            slot1_q       <= '0;
            slot2_q       <= '0;
            data0_q       <= '0;
            data1_q       <= '0;
            data2_q       <= '0;
            data3_q       <= '0;
            lane_valid_q  <= 4'd0;
            frame_valid_q <= 1'b0;
            resync_q      <= 1'b0;
            frame_cnt_q   <= '0;
        end else begin
            phase_q       <= phase_d;
            slot0_q       <= slot0_d;
            slot1_q       <= slot1_d;
            slot2_q       <= slot2_d;
            data0_q       <= data0_d;
            data1_q       <= data1_d;
            data2_q       <= data2_d;
            data3_q       <= data3_d;
            lane_valid_q  <= lane_valid_d;
            frame_valid_q <= frame_valid_d;
            resync_q      <= resync_d;
            frame_cnt_q   <= frame_cnt_d;
        end
    end

    assign data0       = data0_q;
    assign data1       = data1_q;
    assign data2       = data2_q;
    assign data3       = data3_q;
    assign lane_valid  = lane_valid_q;
    assign frame_valid = frame_valid_q;
    assign resync      = resync_q;
    assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_lane_demux_4x9.sv
// Scoreboard bench for lane_demux_4x9: a reference model queues expected
// frames as words are driven; emitted frames are captured and compared.
module tb_lane_demux_4x9;

    localparam int unsigned DATA_W = 9;
    localparam int unsigned CNT_W  = 8;

    typedef struct packed {
        logic [DATA_W-1:0] d0;
        logic [DATA_W-1:0] d1;
        logic [DATA_W-1:0] d2;
        logic [DATA_W-1:0] d3;
        logic [3:0]        lv;
        logic [CNT_W-1:0]  cnt;
    } frame_t;

    logic              clk4f = 1'b0;
    logic              reset = 1'b1;
    logic [DATA_W-1:0] data_in = '0;
    logic              sync_in = 1'b0;
    logic [DATA_W-1:0] data0, data1, data2, data3;
    logic [3:0]        lane_valid;
    logic              frame_valid;
    logic              resync;
    logic [CNT_W-1:0]  frame_cnt;

    int n_cmp = 0;
    int n_err = 0;

    frame_t exp_q[$];
    frame_t obs_q[$];

    // Reference model state
    int                m_phase = 0;
    logic [DATA_W-1:0] m_slot0, m_slot1, m_slot2;
    logic [CNT_W-1:0]  m_cnt = '0;
    logic              exp_resync;

    lane_demux_4x9 #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk4f      (clk4f),
        .reset      (reset),
        .data_in    (data_in),
        .sync_in    (sync_in),
        .data0      (data0),
        .data1      (data1),
        .data2      (data2),
        .data3      (data3),
        .lane_valid (lane_valid),
        .frame_valid(frame_valid),
        .resync     (resync),
        .frame_cnt  (frame_cnt)
    );

    always #5 clk4f = ~clk4f;

    // Drive one word at the negedge, update the model, sample after the edge
    task automatic step(input logic [DATA_W-1:0] w, input logic s, input logic r);
        frame_t f;
        data_in = w;
        sync_in = s;
        reset   = r;
        exp_resync = 1'b0;
        if (r) begin
            m_phase = 0;
            m_slot0 = '0; m_slot1 = '0; m_slot2 = '0;
            m_cnt   = '0;
        end else if (s) begin
            exp_resync = (m_phase != 0);
            m_slot0 = w;
            m_phase = 1;
        end else begin
            case (m_phase)
                0: m_slot0 = w;
                1: m_slot1 = w;
                2: m_slot2 = w;
                default: begin
                    f.d0 = m_slot0; f.d1 = m_slot1; f.d2 = m_slot2; f.d3 = w;
                    f.lv = {w[DATA_W-1], m_slot2[DATA_W-1], m_slot1[DATA_W-1], m_slot0[DATA_W-1]};
                    if (f.lv != 4'd0 && m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
                    f.cnt = m_cnt;
                    exp_q.push_back(f);
                end
            endcase
            m_phase = (m_phase + 1) % 4;
        end
        @(posedge clk4f);
        @(negedge clk4f);
        if (frame_valid) begin
            f.d0 = data0; f.d1 = data1; f.d2 = data2; f.d3 = data3;
            f.lv = lane_valid; f.cnt = frame_cnt;
            obs_q.push_back(f);
        end
        sync_in = 1'b0;
        reset   = 1'b0;
    endtask

    task automatic test_reset();
        step('0, 1'b0, 1'b1);
        step('0, 1'b0, 1'b1);
        n_cmp++;
        if ({data0, data1, data2, data3} !== '0) begin
            n_err++; $display("FAIL reset_data: got %h %h %h %h want 0", data0, data1, data2, data3);
        end
        n_cmp++;
        if ({lane_valid, frame_valid, resync} !== 6'd0) begin
            n_err++; $display("FAIL reset_flags: got lv=%h fv=%b rs=%b want 0", lane_valid, frame_valid, resync);
        end
        n_cmp++;
        if (frame_cnt !== 8'd0) begin
            n_err++; $display("FAIL reset_cnt: got %h want 00", frame_cnt);
        end
    endtask

    task automatic test_basic();
        frame_t e, o;
        step(9'h100, 1'b0, 1'b0);
        step(9'h101, 1'b0, 1'b0);
        step(9'h102, 1'b0, 1'b0);
        n_cmp++;
        if (frame_valid !== 1'b0) begin
            n_err++; $display("FAIL basic_early_fv: got %b want 0", frame_valid);
        end
        step(9'h103, 1'b0, 1'b0);
        n_cmp++;
        if (frame_valid !== 1'b1 || lane_valid !== 4'hF || frame_cnt !== 8'd1) begin
            n_err++; $display("FAIL basic_frame: got fv=%b lv=%h cnt=%h want 1 F 01", frame_valid, lane_valid, frame_cnt);
        end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (obs_q.size() == 0) begin
                n_err++; $display("FAIL basic_sb: got no frame want %h", e);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin n_err++; $display("FAIL basic_sb: got %h want %h", o, e); end
            end
        end
    endtask

    task automatic test_mixed();
        frame_t e, o;
        logic [DATA_W-1:0] words [8];
        words = '{9'h100, 9'h101, 9'h002, 9'h003, 9'h000, 9'h001, 9'h102, 9'h103};
        for (int i = 0; i < 8; i++) begin
            step(words[i], 1'b0, 1'b0);
            n_cmp++;
            if (frame_valid !== (i % 4 == 3)) begin
                n_err++; $display("FAIL mixed_fv_%0d: got %b want %b", i, frame_valid, (i % 4 == 3));
            end
            if (i == 3) begin
                n_cmp++;
                if (lane_valid !== 4'h3) begin n_err++; $display("FAIL mixed_lv_a: got %h want 3", lane_valid); end
            end
        end
        n_cmp++;
        if (lane_valid !== 4'hC || frame_cnt !== 8'd3) begin
            n_err++; $display("FAIL mixed_lv_b: got lv=%h cnt=%h want C 03", lane_valid, frame_cnt);
        end
        // Payload and lanes hold while the next frame is being gathered
        step(9'h0EE, 1'b0, 1'b0);
        n_cmp++;
        if (frame_valid !== 1'b0 || data3 !== 9'h103) begin
            n_err++; $display("FAIL mixed_hold: got fv=%b d3=%h want 0 103", frame_valid, data3);
        end
        step(9'h0EE, 1'b0, 1'b0);
        step(9'h0EE, 1'b0, 1'b0);
        step(9'h0EE, 1'b0, 1'b0);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (obs_q.size() == 0) begin
                n_err++; $display("FAIL mixed_sb: got no frame want %h", e);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin n_err++; $display("FAIL mixed_sb: got %h want %h", o, e); end
            end
        end
    endtask

    task automatic test_invalid();
        frame_t e, o;
        for (int i = 0; i < 4; i++) step(DATA_W'(i), 1'b0, 1'b0);
        n_cmp++;
        if (frame_valid !== 1'b1 || lane_valid !== 4'h0 || frame_cnt !== 8'd3) begin
            n_err++; $display("FAIL invalid_frame: got fv=%b lv=%h cnt=%h want 1 0 03", frame_valid, lane_valid, frame_cnt);
        end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (obs_q.size() == 0) begin
                n_err++; $display("FAIL invalid_sb: got no frame want %h", e);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin n_err++; $display("FAIL invalid_sb: got %h want %h", o, e); end
            end
        end
    endtask

    task automatic test_sync();
        frame_t e, o;
        step(9'h111, 1'b0, 1'b0);
        step(9'h122, 1'b0, 1'b0);
        step(9'h100, 1'b1, 1'b0);
        n_cmp++;
        if (resync !== 1'b1 || frame_valid !== 1'b0) begin
            n_err++; $display("FAIL sync_ph2: got rs=%b fv=%b want 1 0", resync, frame_valid);
        end
        step(9'h1AA, 1'b0, 1'b0);
        step(9'h1BB, 1'b0, 1'b0);
        step(9'h1CC, 1'b0, 1'b0);
        n_cmp++;
        if (frame_valid !== 1'b1 || data0 !== 9'h100 || data3 !== 9'h1CC || frame_cnt !== 8'd4) begin
            n_err++; $display("FAIL sync_frame: got fv=%b d0=%h d3=%h cnt=%h want 1 100 1CC 04", frame_valid, data0, data3, frame_cnt);
        end
        // Sync at phase 0 behaves as free-run
        step(9'h055, 1'b1, 1'b0);
        n_cmp++;
        if (resync !== 1'b0) begin n_err++; $display("FAIL sync_ph0: got rs=%b want 0", resync); end
        step(9'h056, 1'b0, 1'b0);
        step(9'h057, 1'b0, 1'b0);
        // Sync at phase 3 wins over frame completion
        step(9'h158, 1'b1, 1'b0);
        n_cmp++;
        if (resync !== 1'b1 || frame_valid !== 1'b0) begin
            n_err++; $display("FAIL sync_ph3: got rs=%b fv=%b want 1 0", resync, frame_valid);
        end
        step(9'h059, 1'b0, 1'b0);
        step(9'h05A, 1'b0, 1'b0);
        step(9'h05B, 1'b0, 1'b0);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (obs_q.size() == 0) begin
                n_err++; $display("FAIL sync_sb: got no frame want %h", e);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin n_err++; $display("FAIL sync_sb: got %h want %h", o, e); end
            end
        end
        n_cmp++;
        if (obs_q.size() != 0) begin
            n_err++; $display("FAIL sync_extra: got %0d extra frames want 0", obs_q.size());
            obs_q.delete();
        end
    endtask

    task automatic test_reset_saturate();
        frame_t e, o;
        step(9'h1A0, 1'b0, 1'b0);
        step(9'h1A1, 1'b0, 1'b0);
        step(9'h1A2, 1'b1, 1'b1);
        n_cmp++;
        if (frame_valid !== 1'b0 || resync !== 1'b0 || data0 !== '0 || frame_cnt !== 8'd0) begin
            n_err++; $display("FAIL reset_mid: got fv=%b rs=%b d0=%h cnt=%h want 0 0 0 00", frame_valid, resync, data0, frame_cnt);
        end
        for (int i = 0; i < 300; i++) begin
            for (int j = 0; j < 4; j++) step(DATA_W'($urandom_range(0, 511)) | 9'h100, 1'b0, 1'b0);
            if (i == 0) begin
                n_cmp++;
                if (frame_valid !== 1'b1 || frame_cnt !== 8'd1) begin
                    n_err++; $display("FAIL reset_realign: got fv=%b cnt=%h want 1 01", frame_valid, frame_cnt);
                end
            end
        end
        n_cmp++;
        if (frame_cnt !== 8'hFF) begin n_err++; $display("FAIL saturate: got %h want FF", frame_cnt); end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (obs_q.size() == 0) begin
                n_err++; $display("FAIL sat_sb: got no frame want %h", e);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin n_err++; $display("FAIL sat_sb: got %h want %h", o, e); end
            end
        end
    endtask

    initial begin
        @(negedge clk4f);
        test_reset();
        test_basic();
        test_mixed();
        test_invalid();
        test_sync();
        test_reset_saturate();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
